// File: rtl/dot_product_sequencer.sv
// Sequences one shared multiplier/rounding pipeline through a dot product term by term.
// Optional accumulator saturation is enabled by defining DOTP_SAT_EN; default build wraps.
module dot_product_sequencer #(
  parameter int WIDTH_PROD_ROUNDED = 4,
  parameter int WIDTH_ACC          = 6,
  parameter int LEN_W              = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [LEN_W-1:0]              len_m1,
  output logic                          busy,
  output logic [LEN_W-1:0]              addr,
  output logic                          op_req,
  input  logic                          op_rdy,
  input  logic                          prod_vld,
  input  logic [WIDTH_PROD_ROUNDED-1:0] prod_rounded,
  output logic [WIDTH_ACC-1:0]          result,
  output logic                          result_vld,
  input  logic                          result_rdy,
  output logic                          sat_flag,
  output logic [1:0]                    fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never drops and its payload never changes until that transfer.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MSB = WIDTH_ACC - 1;

  state_t               state, state_nxt;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     issue_cnt;
  logic [LEN_W-1:0]     recv_cnt;
  logic [WIDTH_ACC-1:0] acc;
  logic [WIDTH_ACC-1:0] prod_ext;
  logic [WIDTH_ACC-1:0] sum_wrap;
  logic [WIDTH_ACC-1:0] acc_nxt;
  logic                 job_start;
  logic                 op_xfer;
  logic                 acc_en;
  logic                 last_issue;
  logic                 last_recv;

  assign job_start  = (state == IDLE) && start;
  assign op_xfer    = (state == ISSUE) && op_rdy;
  assign acc_en     = prod_vld && ((state == ISSUE) || (state == DRAIN));
  assign last_issue = op_xfer && (issue_cnt == len_q);
  assign last_recv  = acc_en && (state == DRAIN) && (recv_cnt == len_q);

  assign prod_ext = {{(WIDTH_ACC-WIDTH_PROD_ROUNDED){prod_rounded[WIDTH_PROD_ROUNDED-1]}},
                     prod_rounded};
  assign sum_wrap = acc + prod_ext;

`ifdef DOTP_SAT_EN
  localparam logic [WIDTH_ACC-1:0] ACC_MAX = {1'b0, {(WIDTH_ACC-1){1'b1}}};
  localparam logic [WIDTH_ACC-1:0] ACC_MIN = {1'b1, {(WIDTH_ACC-1){1'b0}}};

  logic sat_hit;
  logic sat_q;

  // Overflow only when both addends share a sign and the sum's sign differs.
  always_comb begin
    sat_hit = (acc[MSB] == prod_ext[MSB]) && (sum_wrap[MSB] != acc[MSB]);
    acc_nxt = sum_wrap;
    if (sat_hit) begin
      acc_nxt = acc[MSB] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (job_start) begin
      sat_q <= 1'b0;
    end else if (acc_en && sat_hit) begin
      sat_q <= 1'b1;
    end
  end

  assign sat_flag = sat_q;
`else
  assign acc_nxt  = sum_wrap;
  assign sat_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)      state_nxt = ISSUE;
      ISSUE:   if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (last_recv)  state_nxt = DONE;
      DONE:    if (result_rdy) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Counters stop on their final term so they never wrap, even at the maximum length.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q     <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      acc       <= '0;
    end else if (job_start) begin
      len_q     <= len_m1;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      acc       <= '0;
    end else begin
      if (op_xfer && !last_issue) begin
        issue_cnt <= issue_cnt + 1'b1;
      end
      if (acc_en) begin
        acc <= acc_nxt;
        if (recv_cnt != len_q) begin
          recv_cnt <= recv_cnt + 1'b1;
        end
      end
    end
  end

  // The accumulator only moves during ISSUE/DRAIN, so it doubles as the held result.
  assign busy       = (state != IDLE);
  assign op_req     = (state == ISSUE);
  assign addr       = (state == ISSUE) ? issue_cnt : '0;
  assign result     = acc;
  assign result_vld = (state == DONE);
  assign fsm_state  = state;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer: vector table of whole jobs plus hand sequences
// for DONE back-pressure and mid-job reset. Expected values follow DOTP_SAT_EN when defined.
module tb_dot_product_sequencer;
  localparam int PW = 4;
  localparam int AW = 6;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] len_m1;
  logic          busy;
  logic [LW-1:0] addr;
  logic          op_req;
  logic          op_rdy;
  logic          prod_vld;
  logic [PW-1:0] prod_rounded;
  logic [AW-1:0] result;
  logic          result_vld;
  logic          result_rdy;
  logic          sat_flag;
  logic [1:0]    fsm_state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int                  len;
    int                  lat;
    int                  stall_addr;
    int                  stall_n;
    logic [7:0][PW-1:0]  prods;
    logic [AW-1:0]       exp_result;
    logic                exp_sat;
  } vec_t;

  vec_t          tab[8];
  logic [PW-1:0] prod_tab[8];
  logic          dl_v[4];
  logic [PW-1:0] dl_d[4];
  int            lat;
  logic [LW-1:0] xfer_q[$];
  logic [AW-1:0] exp_q[$];

  always #5 clk = ~clk;

  dot_product_sequencer #(
    .WIDTH_PROD_ROUNDED(PW),
    .WIDTH_ACC(AW),
    .LEN_W(LW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .len_m1(len_m1),
    .busy(busy),
    .addr(addr),
    .op_req(op_req),
    .op_rdy(op_rdy),
    .prod_vld(prod_vld),
    .prod_rounded(prod_rounded),
    .result(result),
    .result_vld(result_vld),
    .result_rdy(result_rdy),
    .sat_flag(sat_flag),
    .fsm_state(fsm_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: the edge sees the inputs set at the previous negedge; the pipeline model
  // returns each transferred operand's product lat cycles later.
  task automatic step();
    logic          x;
    logic [LW-1:0] a;
    x = op_req && op_rdy;
    a = addr;
    if (x) xfer_q.push_back(a);
    @(posedge clk);
    @(negedge clk);
    for (int i = 3; i > 0; i--) begin
      dl_v[i] = dl_v[i-1];
      dl_d[i] = dl_d[i-1];
    end
    dl_v[0]      = x;
    dl_d[0]      = prod_tab[a];
    prod_vld     = dl_v[lat-1];
    prod_rounded = dl_d[lat-1];
  endtask

  function automatic vec_t mk(input int len, input int lt, input int sa, input int sn,
                              input int p0, input int p1, input int p2, input int p3,
                              input int p4, input int p5, input int p6, input int p7,
                              input logic [AW-1:0] er, input logic es);
    vec_t r;
    r.len = len; r.lat = lt; r.stall_addr = sa; r.stall_n = sn;
    r.prods[0] = PW'(p0); r.prods[1] = PW'(p1); r.prods[2] = PW'(p2); r.prods[3] = PW'(p3);
    r.prods[4] = PW'(p4); r.prods[5] = PW'(p5); r.prods[6] = PW'(p6); r.prods[7] = PW'(p7);
    r.exp_result = er;
    r.exp_sat    = es;
    return r;
  endfunction

  task automatic run_job(input vec_t v, input bit accept);
    int   edges;
    int   stall_left;
    bit   held;
    bit   ok;
    for (int i = 0; i < 8; i++) prod_tab[i] = v.prods[i];
    lat = v.lat;
    xfer_q.delete();
    exp_q.push_back(v.exp_result);
    len_m1 = LW'(v.len);
    start  = 1'b1;
    op_rdy = 1'b1;
    step();
    start  = 1'b0;
    len_m1 = LW'($urandom_range(0, 7));
    check("busy_after_start", busy, 1);
    check("op_req_first", op_req, 1);
    check("addr_first", addr, 0);
    edges      = 0;
    stall_left = v.stall_n;
    held       = 1'b0;
    while (!result_vld && edges < 200) begin
      if (held) begin
        check("stall_addr_hold", addr, v.stall_addr);
        check("stall_req_hold", op_req, 1);
      end
      held   = 1'b0;
      op_rdy = 1'b1;
      if (op_req && int'(addr) == v.stall_addr && stall_left > 0) begin
        op_rdy = 1'b0;
        stall_left--;
        held = 1'b1;
      end
      step();
      edges++;
    end
    op_rdy = 1'b1;
    check("job_timeout", result_vld, 1);
    check("latency", edges, v.len + 1 + v.lat + v.stall_n);
    check("result", result, exp_q.pop_front());
    check("sat_flag", sat_flag, v.exp_sat);
    check("xfer_count", xfer_q.size(), v.len + 1);
    ok = 1'b1;
    foreach (xfer_q[i]) if (xfer_q[i] != LW'(i)) ok = 1'b0;
    check("addr_order", ok, 1);
    if (accept) begin
      result_rdy = 1'b1;
      step();
      result_rdy = 1'b0;
      check("vld_after_accept", result_vld, 0);
      check("busy_after_accept", busy, 0);
      check("result_kept", result, v.exp_result);
      check("sat_kept", sat_flag, v.exp_sat);
    end
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; start = 1'b0; len_m1 = '0; op_rdy = 1'b0; prod_vld = 1'b0;
    prod_rounded = '0; result_rdy = 1'b0; lat = 1;
    for (int i = 0; i < 4; i++) begin dl_v[i] = 1'b0; dl_d[i] = '0; end
    for (int i = 0; i < 8; i++) prod_tab[i] = '0;

    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("rst_busy", busy, 0);
    check("rst_addr", addr, 0);
    check("rst_op_req", op_req, 0);
    check("rst_result", result, 0);
    check("rst_result_vld", result_vld, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_state", fsm_state, 0);

    tab[0] = mk(3, 1, -1, 0,  3, -2,  5,  1,  0,  0,  0,  0, 6'h07, 1'b0);
`ifdef DOTP_SAT_EN
    tab[1] = mk(7, 1, -1, 0,  7,  7,  7,  7,  7,  7,  7,  7, 6'h1F, 1'b1);
    tab[2] = mk(7, 2, -1, 0, -7, -7, -7, -7, -7, -7, -7, -7, 6'h20, 1'b1);
    tab[6] = mk(7, 1, -1, 0,  7,  7,  7,  7,  7, -7, -7, -7, 6'h0A, 1'b1);
    tab[7] = mk(4, 3,  2, 1, -7, -7, -7, -7, -7,  0,  0,  0, 6'h20, 1'b1);
`else
    tab[1] = mk(7, 1, -1, 0,  7,  7,  7,  7,  7,  7,  7,  7, 6'h38, 1'b0);
    tab[2] = mk(7, 2, -1, 0, -7, -7, -7, -7, -7, -7, -7, -7, 6'h08, 1'b0);
    tab[6] = mk(7, 1, -1, 0,  7,  7,  7,  7,  7, -7, -7, -7, 6'h0E, 1'b0);
    tab[7] = mk(4, 3,  2, 1, -7, -7, -7, -7, -7,  0,  0,  0, 6'h1D, 1'b0);
`endif
    tab[3] = mk(3, 1,  1, 2,  2, -3,  4,  1,  0,  0,  0,  0, 6'h04, 1'b0);
    tab[4] = mk(0, 1, -1, 0, -5,  0,  0,  0,  0,  0,  0,  0, 6'h3B, 1'b0);
    tab[5] = mk(2, 2, -1, 0,  7,  7, -3,  0,  0,  0,  0,  0, 6'h0B, 1'b0);

    for (int t = 0; t < 8; t++) run_job(tab[t], 1'b1);

    // Result held under back-pressure; start pulses in DONE must not launch a job.
    run_job(tab[0], 1'b0);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin start = 1'b1; len_m1 = '0; end
      step();
      start = 1'b0;
      check("done_hold_vld", result_vld, 1);
      check("done_hold_result", result, 6'h07);
      check("done_hold_op_req", op_req, 0);
    end
    result_rdy = 1'b1;
    start      = 1'b1;
    step();
    result_rdy = 1'b0;
    start      = 1'b0;
    check("done_exit_state", fsm_state, 0);
    check("done_exit_vld", result_vld, 0);
    check("done_exit_busy", busy, 0);

    // Next start accepted from IDLE, then reset lands mid-issue at addr 2.
    for (int i = 0; i < 8; i++) prod_tab[i] = PW'(i + 1);
    lat    = 1;
    len_m1 = 3'd3;
    start  = 1'b1;
    step();
    start = 1'b0;
    check("restart_busy", busy, 1);
    check("restart_op_req", op_req, 1);
    guard = 0;
    while (!(op_req && addr == 3'd2) && guard < 20) begin
      step();
      guard++;
    end
    check("reach_addr2", addr, 2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_addr", addr, 0);
    check("midrst_op_req", op_req, 0);
    check("midrst_result", result, 0);
    check("midrst_vld", result_vld, 0);
    check("midrst_sat", sat_flag, 0);
    check("midrst_state", fsm_state, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      prod_vld     = 1'b1;
      prod_rounded = 4'h5;
    end
    step();
    check("stale_prod_result", result, 0);
    check("stale_prod_busy", busy, 0);

    run_job(tab[5], 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
